// File: rtl/osd_box_overlay_pkg.sv
// Shared definitions for the OSD box overlay: coordinate widths, defaults and the box record.
package osd_box_overlay_pkg;

   localparam int unsigned COORD_W       = 11;
   localparam int unsigned CMP_W         = COORD_W + 1;
   localparam int unsigned NUM_BOXES_DEF = 4;
   localparam int unsigned BORDER_W_DEF  = 2;
   localparam int unsigned H_ACTIVE_DEF  = 512;
   localparam int unsigned SPLIT_X       = 512;
   localparam logic [15:0] BOX_COLOR_DEF = 16'hF800;

   typedef logic [CMP_W-1:0] cmp_t;

   typedef struct packed {
      logic               en;
      logic [COORD_W-1:0] x0;
      logic [COORD_W-1:0] y0;
      logic [COORD_W-1:0] x1;
      logic [COORD_W-1:0] y1;
   } box_t;

   // Inverted corners turn a box off entirely instead of wrapping.
   function automatic logic box_ok(input box_t b);
      return b.en && (b.x0 <= b.x1) && (b.y0 <= b.y1);
   endfunction

endpackage

// File: rtl/osd_box_overlay_hit.sv
// Combinational outline test of one pixel against one box.
module osd_box_hit
   import osd_box_overlay_pkg::*;
#(
   parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
   parameter int unsigned BORDER_W = BORDER_W_DEF
) (
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   input  box_t               box,
   output logic               hit
);

   localparam cmp_t B    = cmp_t'(BORDER_W);
   localparam cmp_t XLIM = cmp_t'(H_ACTIVE);

   cmp_t xe, ye, x0, y0, x1, y1;
   logic outer, inner;

   // One extra bit so x+B and x0+B never wrap.
   always_comb begin
      xe    = {1'b0, x};
      ye    = {1'b0, y};
      x0    = {1'b0, box.x0};
      y0    = {1'b0, box.y0};
      x1    = {1'b0, box.x1};
      y1    = {1'b0, box.y1};
      outer = (xe >= x0) && (xe <= x1) && (ye >= y0) && (ye <= y1);
      inner = (xe >= x0 + B) && (xe + B <= x1) && (ye >= y0 + B) && (ye + B <= y1);
      hit   = box_ok(box) && outer && !inner && (xe < XLIM);
   end

endmodule

// File: rtl/osd_box_overlay.sv
// Draws up to NUM_BOXES outlines over the camera stream; shadow bank is applied only at frame start.
module osd_box_overlay
   import osd_box_overlay_pkg::*;
#(
   parameter int unsigned NUM_BOXES = NUM_BOXES_DEF,
   parameter int unsigned H_ACTIVE  = H_ACTIVE_DEF,
   parameter int unsigned BORDER_W  = BORDER_W_DEF,
   parameter logic [15:0] BOX_COLOR = BOX_COLOR_DEF,
   localparam int unsigned IDX_W    = (NUM_BOXES > 1) ? $clog2(NUM_BOXES) : 1
) (
   input  logic               pixel_clk,
   input  logic               rst,
   input  logic [COORD_W-1:0] pixel_x,
   input  logic [COORD_W-1:0] pixel_y,
   input  logic [15:0]        in_pixel,
   input  logic               in_valid,
   input  logic               osd_enable,
   input  logic               cfg_wr,
   input  logic [IDX_W-1:0]   cfg_idx,
   input  logic               cfg_en,
   input  logic [COORD_W-1:0] cfg_x0,
   input  logic [COORD_W-1:0] cfg_y0,
   input  logic [COORD_W-1:0] cfg_x1,
   input  logic [COORD_W-1:0] cfg_y1,
   input  logic               cfg_commit,
   output logic               cfg_busy,
   output logic               cfg_err,
   output logic [15:0]        out_pixel,
   output logic               out_valid,
   output logic [COORD_W-1:0] out_x,
   output logic [COORD_W-1:0] out_y
);

   localparam int unsigned STAGES = 2;

   box_t shadow   [NUM_BOXES];
   box_t active   [NUM_BOXES];
   box_t cmp_bank [NUM_BOXES];

   logic                 frame_start, apply;
   logic [NUM_BOXES-1:0] hit_c, hit_s1;
   logic [15:0]          pix_s1;
   logic [COORD_W-1:0]   x_s1, y_s1;
   logic                 osd_en_s1;
   logic [STAGES:1]      vld_pipe;

   assign frame_start = in_valid && (pixel_x == '0) && (pixel_y == '0);
   assign apply       = frame_start && cfg_busy;

   // On the committing edge the frame-start pixel already sees the new bank.
   always_comb begin
      for (int i = 0; i < NUM_BOXES; i++)
         cmp_bank[i] = apply ? shadow[i] : active[i];
   end

   for (genvar g = 0; g < NUM_BOXES; g++) begin : g_hit
      osd_box_hit #(.H_ACTIVE(H_ACTIVE), .BORDER_W(BORDER_W)) u_hit (
         .x   (pixel_x),
         .y   (pixel_y),
         .box (cmp_bank[g]),
         .hit (hit_c[g])
      );
   end

   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_BOXES; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
         cfg_busy <= 1'b0;
         cfg_err  <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_BOXES; i++) begin
            if (cfg_wr && !cfg_busy && (cfg_idx == IDX_W'(i)))
               shadow[i] <= '{en: cfg_en, x0: cfg_x0, y0: cfg_y0, x1: cfg_x1, y1: cfg_y1};
            if (apply)
               active[i] <= shadow[i];
         end
         // A commit on the frame-start cycle re-arms for the following frame.
         cfg_busy <= (cfg_busy && !apply) || cfg_commit;
         cfg_err  <= cfg_wr && cfg_busy;
      end
   end

   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         vld_pipe  <= '0;
         hit_s1    <= '0;
         pix_s1    <= '0;
         x_s1      <= '0;
         y_s1      <= '0;
         osd_en_s1 <= 1'b0;
         out_pixel <= '0;
         out_x     <= '0;
         out_y     <= '0;
      end else begin
         vld_pipe  <= {vld_pipe[STAGES-1:1], in_valid};
         hit_s1    <= hit_c;
         pix_s1    <= in_pixel;
         x_s1      <= pixel_x;
         y_s1      <= pixel_y;
         osd_en_s1 <= osd_enable;
         if (!vld_pipe[1])
            out_pixel <= '0;
         else if (osd_en_s1 && (|hit_s1))
            out_pixel <= BOX_COLOR;
         else
            out_pixel <= pix_s1;
         out_x     <= x_s1;
         out_y     <= y_s1;
      end
   end

   assign out_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_osd_box_overlay.sv
// Directed bench for osd_box_overlay: outline geometry, latency, commit handshake, clipping, reset, bypass.
module tb_osd_box_overlay;

   logic        pixel_clk = 1'b0;
   logic        rst;
   logic [10:0] pixel_x, pixel_y;
   logic [15:0] in_pixel;
   logic        in_valid, osd_enable;
   logic        cfg_wr, cfg_en, cfg_commit;
   logic [1:0]  cfg_idx;
   logic [10:0] cfg_x0, cfg_y0, cfg_x1, cfg_y1;
   logic        cfg_busy, cfg_err, out_valid;
   logic [15:0] out_pixel;
   logic [10:0] out_x, out_y;

   int n_chk  = 0;
   int n_fail = 0;

   localparam logic [15:0] RED = 16'hF800;

   always #5 pixel_clk = ~pixel_clk;

   osd_box_overlay dut (
      .pixel_clk (pixel_clk), .rst (rst),
      .pixel_x (pixel_x), .pixel_y (pixel_y), .in_pixel (in_pixel), .in_valid (in_valid),
      .osd_enable (osd_enable),
      .cfg_wr (cfg_wr), .cfg_idx (cfg_idx), .cfg_en (cfg_en),
      .cfg_x0 (cfg_x0), .cfg_y0 (cfg_y0), .cfg_x1 (cfg_x1), .cfg_y1 (cfg_y1),
      .cfg_commit (cfg_commit), .cfg_busy (cfg_busy), .cfg_err (cfg_err),
      .out_pixel (out_pixel), .out_valid (out_valid), .out_x (out_x), .out_y (out_y)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge pixel_clk);
      #1;
   endtask

   task automatic cfg_write(input int idx, input logic en, input int x0, input int y0,
                            input int x1, input int y1);
      cfg_wr  = 1'b1;
      cfg_idx = 2'(idx);
      cfg_en  = en;
      cfg_x0  = 11'(x0);
      cfg_y0  = 11'(y0);
      cfg_x1  = 11'(x1);
      cfg_y1  = 11'(y1);
      step();
      cfg_wr  = 1'b0;
   endtask

   task automatic commit();
      cfg_commit = 1'b1;
      step();
      cfg_commit = 1'b0;
   endtask

   // One valid pixel, then idle; result is on the output after the second edge.
   task automatic probe(input string tag, input int x, input int y, input logic [15:0] pix,
                        input logic [15:0] exp);
      pixel_x  = 11'(x);
      pixel_y  = 11'(y);
      in_pixel = pix;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      chk(tag, 32'(out_pixel), 32'(exp));
   endtask

   function automatic logic [15:0] pat(input int x, input int y);
      return 16'(x * 37 + y * 1031) ^ 16'h5A5A;
   endfunction

   initial begin
      logic [15:0] prev;
      logic        have_prev;
      rst = 1'b1; pixel_x = '0; pixel_y = '0; in_pixel = '0; in_valid = 1'b0;
      osd_enable = 1'b1; cfg_wr = 1'b0; cfg_idx = '0; cfg_en = 1'b0;
      cfg_x0 = '0; cfg_y0 = '0; cfg_x1 = '0; cfg_y1 = '0; cfg_commit = 1'b0;
      step(); step();
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_pixel", 32'(out_pixel), 32'd0);
      chk("rst_busy",  32'(cfg_busy),  32'd0);
      chk("rst_err",   32'(cfg_err),   32'd0);
      rst = 1'b0;
      step();

      // Basic outline, box0 (10,20)-(100,80)
      cfg_write(0, 1'b1, 10, 20, 100, 80);
      commit();
      chk("t1_busy_set", 32'(cfg_busy), 32'd1);
      probe("t1_fs",     0,  0, 16'h1234, 16'h1234);
      chk("t1_busy_clr", 32'(cfg_busy), 32'd0);
      probe("t1_10_50",  10, 50, 16'h0101, RED);
      probe("t1_99_50",  99, 50, 16'h0102, RED);
      probe("t1_50_21",  50, 21, 16'h0103, RED);
      probe("t1_100_80", 100, 80, 16'h0104, RED);
      probe("t1_12_22",  12, 22, 16'h0105, 16'h0105);
      probe("t1_98_78",  98, 78, 16'h0106, 16'h0106);
      probe("t1_50_50",  50, 50, 16'h0107, 16'h0107);
      probe("t1_9_50",   9,  50, 16'h0108, 16'h0108);
      probe("t1_101_50", 101, 50, 16'h0109, 16'h0109);

      // Latency
      pixel_x = 11'd5; pixel_y = 11'd5; in_pixel = 16'hABCD; in_valid = 1'b1;
      step();
      chk("t2_vld_c1", 32'(out_valid), 32'd0);
      in_valid = 1'b0;
      step();
      chk("t2_vld_c2", 32'(out_valid), 32'd1);
      chk("t2_x",      32'(out_x),     32'd5);
      chk("t2_y",      32'(out_y),     32'd5);
      chk("t2_pix",    32'(out_pixel), 32'hABCD);
      step();
      chk("t2_vld_c3", 32'(out_valid), 32'd0);
      chk("t2_idle",   32'(out_pixel), 32'd0);

      // Commit handshake
      cfg_write(1, 1'b1, 0, 0, 20, 20);
      commit();
      chk("t3_busy", 32'(cfg_busy), 32'd1);
      probe("t3_pending", 1, 10, 16'h2222, 16'h2222);
      cfg_write(1, 1'b0, 0, 0, 0, 0);
      chk("t3_err_pulse", 32'(cfg_err), 32'd1);
      step();
      chk("t3_err_clr",   32'(cfg_err), 32'd0);
      probe("t3_fs_new", 0, 0, 16'h3333, RED);
      chk("t3_busy_clr", 32'(cfg_busy), 32'd0);
      probe("t3_kept",   1, 10, 16'h4444, RED);
      probe("t3_inner",  10, 10, 16'h4445, 16'h4445);

      // Clipping and degenerate boxes
      cfg_write(1, 1'b1, 200, 100, 150, 120);
      cfg_write(2, 1'b1, 500, 0, 600, 10);
      cfg_write(3, 1'b1, 30, 30, 32, 32);
      commit();
      probe("t4_fs",     0,   0, 16'h5555, 16'h5555);
      probe("t4_511_0",  511, 0, 16'h5001, RED);
      probe("t4_500_5",  500, 5, 16'h5002, RED);
      probe("t4_512_0",  512, 0, 16'h5003, 16'h5003);
      probe("t4_600_0",  600, 0, 16'h5004, 16'h5004);
      probe("t4_511_5",  511, 5, 16'h5005, 16'h5005);
      for (int yy = 30; yy <= 32; yy++)
         for (int xx = 30; xx <= 32; xx++)
            probe("t4_small", xx, yy, 16'h6000, RED);
      probe("t4_29_31",  29, 31, 16'h6001, 16'h6001);
      probe("t4_33_31",  33, 31, 16'h6002, 16'h6002);
      probe("t4_inv_a",  150, 100, 16'h6003, 16'h6003);
      probe("t4_inv_b",  200, 110, 16'h6004, 16'h6004);

      // Mid-frame reset
      commit();
      chk("t5_busy_pre", 32'(cfg_busy), 32'd1);
      in_valid = 1'b1; pixel_x = 11'd3; pixel_y = 11'd3; in_pixel = 16'h0303;
      step();
      pixel_x = 11'd4; in_pixel = 16'h0403;
      step();
      chk("t5_stream", 32'(out_valid), 32'd1);
      rst = 1'b1; pixel_x = 11'd5; in_pixel = 16'h0503;
      step();
      rst = 1'b0;
      chk("t5_vld", 32'(out_valid), 32'd0);
      chk("t5_pix", 32'(out_pixel), 32'd0);
      chk("t5_x",   32'(out_x),     32'd0);
      chk("t5_busy", 32'(cfg_busy), 32'd0);
      pixel_x = 11'd6; in_pixel = 16'h0603;
      step();
      chk("t5_flushed", 32'(out_valid), 32'd0);
      in_valid = 1'b0;
      step();
      chk("t5_resume_v", 32'(out_valid), 32'd1);
      chk("t5_resume_p", 32'(out_pixel), 32'h0603);
      probe("t5_fs",    0,  0,  16'h7001, 16'h7001);
      probe("t5_31_31", 31, 31, 16'h7002, 16'h7002);
      probe("t5_10_50", 10, 50, 16'h7003, 16'h7003);

      // Bypass with four overlapping boxes over a reduced raster
      cfg_write(0, 1'b1, 0, 0, 63, 15);
      cfg_write(1, 1'b1, 2, 2, 20, 10);
      cfg_write(2, 1'b1, 10, 0, 40, 15);
      cfg_write(3, 1'b1, 5, 5, 5, 5);
      commit();
      osd_enable = 1'b0;
      have_prev = 1'b0;
      prev = '0;
      for (int yy = 0; yy < 16; yy++) begin
         for (int xx = 0; xx < 64; xx++) begin
            pixel_x = 11'(xx); pixel_y = 11'(yy); in_pixel = pat(xx, yy); in_valid = 1'b1;
            step();
            if (have_prev) chk("t6_bypass", 32'(out_pixel), 32'(prev));
            prev = pat(xx, yy);
            have_prev = 1'b1;
         end
      end
      in_valid = 1'b0;
      step();
      chk("t6_bypass_last", 32'(out_pixel), 32'(prev));
      osd_enable = 1'b1;
      probe("t6_on_0_0", 0, 0, 16'h8001, RED);
      probe("t6_on_5_5", 5, 5, 16'h8002, RED);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
